// File: rtl/ysyx_22040931_mem_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and transaction owner.
package ysyx_22040931_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ysyx_22040931_ARB_IDLE = 2'd0,
        ysyx_22040931_ARB_REQ  = 2'd1,
        ysyx_22040931_ARB_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        ysyx_22040931_ARB_OWN_IF = 1'b0,
        ysyx_22040931_ARB_OWN_LS = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/ysyx_22040931_arb_pick.sv
// Grant selection between fetch and LSU. A flushed fetch never wins. On a tie
// the side that was not granted last wins, so a last_grant pinned to IF gives
// a fixed LSU priority.
module ysyx_22040931_arb_pick
    import ysyx_22040931_mem_arbiter_pkg::*;
(
    input  logic       if_valid,
    input  logic       ls_valid,
    input  logic       if_flush,
    input  arb_owner_t last_grant,
    output logic       grant_if,
    output logic       grant_ls
);

    logic if_live;

    // One-hot grant from the live requests and the tie-break pointer
    always_comb begin
        if_live  = if_valid & ~if_flush;
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (if_live && ls_valid) begin
            if (last_grant == ysyx_22040931_ARB_OWN_LS) begin
                grant_if = 1'b1;
            end else begin
                grant_ls = 1'b1;
            end
        end else begin
            grant_if = if_live;
            grant_ls = ls_valid;
        end
    end

endmodule

// File: rtl/ysyx_22040931_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and LSU.
// Define YSYX_22040931_ARB_RR_EN for round-robin tie breaking; otherwise the
// LSU wins every tie.
module ysyx_22040931_mem_arbiter
    import ysyx_22040931_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              ls_wen,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [MASK_W-1:0] ls_wmask,
    output logic              ls_resp_valid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_reg, state_next;
    arb_owner_t        owner_reg, owner_next;
    logic              drop_reg, drop_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              wen_reg, wen_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [MASK_W-1:0] wmask_reg, wmask_next;
    logic              if_resp_reg, if_resp_next;
    logic              ls_resp_reg, ls_resp_next;
    logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
    logic [DATA_W-1:0] ls_rdata_reg, ls_rdata_next;

    arb_owner_t        last_grant;
    logic              grant_if;
    logic              grant_ls;
    logic              in_idle;

    assign in_idle = (state_reg == ysyx_22040931_ARB_IDLE);

    ysyx_22040931_arb_pick u_pick (
        .if_valid   (if_req_valid),
        .ls_valid   (ls_req_valid),
        .if_flush   (if_flush),
        .last_grant (last_grant),
        .grant_if   (grant_if),
        .grant_ls   (grant_ls)
    );

`ifdef YSYX_22040931_ARB_RR_EN
    arb_owner_t last_grant_reg, last_grant_next;

    assign last_grant = last_grant_reg;

    // Remember which side won the most recent grant
    always_comb begin
        last_grant_next = last_grant_reg;
        if (in_idle && grant_ls) begin
            last_grant_next = ysyx_22040931_ARB_OWN_LS;
        end else if (in_idle && grant_if) begin
            last_grant_next = ysyx_22040931_ARB_OWN_IF;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_reg <= ysyx_22040931_ARB_OWN_IF;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end
`else
    // Pretending IF always won last makes every tie go to the LSU.
    assign last_grant = ysyx_22040931_ARB_OWN_IF;
`endif

    // Readies are gated by reset so nothing is accepted while reset is held.
    assign if_req_ready  = in_idle & grant_if & reset;
    assign ls_req_ready  = in_idle & grant_ls & reset;

    assign mem_req_valid = (state_reg == ysyx_22040931_ARB_REQ);
    assign mem_addr      = addr_reg;
    assign mem_wen       = wen_reg;
    assign mem_wdata     = wdata_reg;
    assign mem_wmask     = wmask_reg;

    assign if_resp_valid = if_resp_reg;
    assign if_rdata      = if_rdata_reg;
    assign ls_resp_valid = ls_resp_reg;
    assign ls_rdata      = ls_rdata_reg;

    // Next-state logic: grant and latch in IDLE, handshake in REQ, route response in WAIT
    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        drop_next     = drop_reg;
        addr_next     = addr_reg;
        wen_next      = wen_reg;
        wdata_next    = wdata_reg;
        wmask_next    = wmask_reg;
        if_resp_next  = 1'b0;
        ls_resp_next  = 1'b0;
        if_rdata_next = if_rdata_reg;
        ls_rdata_next = ls_rdata_reg;
        case (state_reg)
            ysyx_22040931_ARB_IDLE: begin
                drop_next = 1'b0;
                if (grant_ls) begin
                    owner_next = ysyx_22040931_ARB_OWN_LS;
                    addr_next  = ls_addr;
                    wen_next   = ls_wen;
                    wdata_next = ls_wdata;
                    wmask_next = ls_wmask;
                    state_next = ysyx_22040931_ARB_REQ;
                end else if (grant_if) begin
                    owner_next = ysyx_22040931_ARB_OWN_IF;
                    addr_next  = if_addr;
                    wen_next   = 1'b0;
                    wdata_next = '0;
                    wmask_next = '0;
                    state_next = ysyx_22040931_ARB_REQ;
                end
            end
            ysyx_22040931_ARB_REQ: begin
                // A redirect cannot retract the request; it only marks the fetch stale.
                if (owner_reg == ysyx_22040931_ARB_OWN_IF && if_flush) begin
                    drop_next = 1'b1;
                end
                if (mem_req_ready) begin
                    state_next = ysyx_22040931_ARB_WAIT;
                end
            end
            ysyx_22040931_ARB_WAIT: begin
                if (owner_reg == ysyx_22040931_ARB_OWN_IF && if_flush) begin
                    drop_next = 1'b1;
                end
                if (mem_resp_valid) begin
                    state_next = ysyx_22040931_ARB_IDLE;
                    drop_next  = 1'b0;
                    if (owner_reg == ysyx_22040931_ARB_OWN_LS) begin
                        ls_resp_next  = 1'b1;
                        ls_rdata_next = mem_rdata;
                    end else if (!drop_reg && !if_flush) begin
                        if_resp_next  = 1'b1;
                        if_rdata_next = mem_rdata;
                    end
                end
            end
            default: begin
                state_next = ysyx_22040931_ARB_IDLE;
            end
        endcase
    end

    // State, request latch and response registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= ysyx_22040931_ARB_IDLE;
            owner_reg    <= ysyx_22040931_ARB_OWN_IF;
            drop_reg     <= 1'b0;
            addr_reg     <= '0;
            wen_reg      <= 1'b0;
            wdata_reg    <= '0;
            wmask_reg    <= '0;
            if_resp_reg  <= 1'b0;
            ls_resp_reg  <= 1'b0;
            if_rdata_reg <= '0;
            ls_rdata_reg <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            drop_reg     <= drop_next;
            addr_reg     <= addr_next;
            wen_reg      <= wen_next;
            wdata_reg    <= wdata_next;
            wmask_reg    <= wmask_next;
            if_resp_reg  <= if_resp_next;
            ls_resp_reg  <= ls_resp_next;
            if_rdata_reg <= if_rdata_next;
            ls_rdata_reg <= ls_rdata_next;
        end
    end

endmodule

// File: tb/tb_ysyx_22040931_mem_arbiter.sv
// Bench for ysyx_22040931_mem_arbiter: a transaction-level reference model checks
// every cycle, directed sequences pin literal expectations. Honours
// YSYX_22040931_ARB_RR_EN for the grant-order expectations.
`timescale 1ns/1ps
module tb_ysyx_22040931_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          if_req_valid = 1'b0;
    logic          if_flush = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          ls_req_valid = 1'b0;
    logic [AW-1:0] ls_addr = '0;
    logic          ls_wen = 1'b0;
    logic [DW-1:0] ls_wdata = '0;
    logic [MW-1:0] ls_wmask = '0;
    logic          mem_req_ready = 1'b0;
    logic          mem_resp_valid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    logic          if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid;
    logic [DW-1:0] if_rdata, ls_rdata, mem_wdata;
    logic          mem_req_valid, mem_wen;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] mem_wmask;

    ysyx_22040931_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h13;
        return {a[31:0], ~a[31:0]};
    endfunction

    // Memory responder: accepts after ready_delay stalled cycles, answers resp_delay cycles later
    int          ready_delay = 0;
    int          resp_delay = 1;
    logic        stray_resp = 1'b0;
    int          wait_cnt = 0;
    int          resp_cnt = 0;
    logic [63:0] resp_data = '0;

    initial begin
        forever begin
            tick();
            mem_req_ready  = 1'b0;
            mem_resp_valid = stray_resp;
            mem_rdata      = 64'h0bad_0bad_0bad_0bad;
            if (!reset) wait_cnt = 0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = resp_data;
                end
            end
            if (reset && mem_req_valid) begin
                if (wait_cnt >= ready_delay) begin
                    mem_req_ready = 1'b1;
                    wait_cnt      = 0;
                    resp_cnt      = resp_delay;
                    resp_data     = mem_word(mem_addr);
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Reference model: one transaction record, filled on grant, retired on response
    logic        m_busy = 0, m_issued = 0, m_owner_ls = 0, m_stale = 0, m_last_ls = 0;
    logic [63:0] m_addr = '0, m_wdata = '0;
    logic        m_wen = 0;
    logic [7:0]  m_wmask = '0;
    logic        m_if_resp = 0, m_ls_resp = 0;
    logic [63:0] m_if_data = '0, m_ls_data = '0;
    logic        e_if, e_ls, e_mreq, if_live, n_if, n_ls, both;

    always @(negedge clock) begin
        if (!reset) begin
            chk("rst_if_ready", if_req_ready, 0);
            chk("rst_ls_ready", ls_req_ready, 0);
            chk("rst_if_resp", if_resp_valid, 0);
            chk("rst_ls_resp", ls_resp_valid, 0);
            chk("rst_mem_req", mem_req_valid, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wen", mem_wen, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_mem_wmask", mem_wmask, 0);
            chk("rst_if_rdata", if_rdata, 0);
            chk("rst_ls_rdata", ls_rdata, 0);
            m_busy = 0; m_issued = 0; m_owner_ls = 0; m_stale = 0; m_last_ls = 0;
            m_if_resp = 0; m_ls_resp = 0;
        end else begin
            e_if = 0; e_ls = 0;
            if (!m_busy) begin
                if_live = if_req_valid && !if_flush;
                both    = if_live && ls_req_valid;
`ifdef YSYX_22040931_ARB_RR_EN
                if (both) begin e_if = m_last_ls; e_ls = !m_last_ls; end
`else
                if (both) e_ls = 1;
`endif
                else begin e_if = if_live; e_ls = ls_req_valid; end
            end
            e_mreq = m_busy && !m_issued;
            chk("if_req_ready", if_req_ready, e_if);
            chk("ls_req_ready", ls_req_ready, e_ls);
            chk("mem_req_valid", mem_req_valid, e_mreq);
            chk("if_resp_valid", if_resp_valid, m_if_resp);
            chk("ls_resp_valid", ls_resp_valid, m_ls_resp);
            if (m_if_resp) chk("if_rdata", if_rdata, m_if_data);
            if (m_ls_resp) chk("ls_rdata", ls_rdata, m_ls_data);
            if (e_mreq) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_wen", mem_wen, m_wen);
                chk("mem_wdata", mem_wdata, m_wdata);
                chk("mem_wmask", mem_wmask, m_wmask);
            end
            n_if = 0; n_ls = 0;
            if (m_busy && m_issued && mem_resp_valid) begin
                $display("txn %s addr=%h wen=%0d data=%h%s", m_owner_ls ? "LS" : "IF", m_addr, m_wen,
                         mem_rdata, (!m_owner_ls && (m_stale || if_flush)) ? " dropped" : "");
                if (m_owner_ls) begin n_ls = 1; m_ls_data = mem_rdata; end
                else if (!m_stale && !if_flush) begin n_if = 1; m_if_data = mem_rdata; end
                m_busy = 0;
            end else if (m_busy) begin
                if (!m_issued && mem_req_ready) m_issued = 1;
                if (!m_owner_ls && if_flush) m_stale = 1;
            end else if (e_ls) begin
                m_busy = 1; m_issued = 0; m_owner_ls = 1; m_stale = 0; m_last_ls = 1;
                m_addr = ls_addr; m_wen = ls_wen; m_wdata = ls_wdata; m_wmask = ls_wmask;
            end else if (e_if) begin
                m_busy = 1; m_issued = 0; m_owner_ls = 0; m_stale = 0; m_last_ls = 0;
                m_addr = if_addr; m_wen = 0; m_wdata = '0; m_wmask = '0;
            end
            m_if_resp = n_if;
            m_ls_resp = n_ls;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    logic exp3 [4];
    int   cyc;
    logic got;
    int   pulses;

    initial begin
`ifdef YSYX_22040931_ARB_RR_EN
        exp3[0] = 1; exp3[1] = 0; exp3[2] = 1; exp3[3] = 0;
`else
        exp3[0] = 1; exp3[1] = 1; exp3[2] = 1; exp3[3] = 1;
`endif
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // Fetch only, best-case latency
        tick(); if_req_valid = 1; if_addr = 64'h8000_0000;
        smp(); chk("t1_if_ready_c0", if_req_ready, 1); chk("t1_ls_ready_c0", ls_req_ready, 0);
        tick(); if_req_valid = 0;
        smp(); chk("t1_mreq_c1", mem_req_valid, 1); chk("t1_maddr_c1", mem_addr, 64'h8000_0000);
        chk("t1_mwen_c1", mem_wen, 0); chk("t1_mwmask_c1", mem_wmask, 0);
        tick(); smp(); chk("t1_mreq_c2", mem_req_valid, 0); chk("t1_ifresp_c2", if_resp_valid, 0);
        tick(); smp(); chk("t1_ifresp_c3", if_resp_valid, 1); chk("t1_ifdata_c3", if_rdata, 64'h13);
        chk("t1_lsresp_c3", ls_resp_valid, 0);

        // Simultaneous requests: LSU first, IF at the next IDLE
        tick(); if_req_valid = 1; if_addr = 64'h8000_0040; ls_req_valid = 1; ls_addr = 64'h200;
        smp(); chk("t2_ls_first", ls_req_ready, 1); chk("t2_if_held", if_req_ready, 0);
        tick(); ls_req_valid = 0;
        cyc = 1; got = 0;
        for (int i = 0; i < 10; i++) begin
            smp();
            if (if_req_ready) begin got = 1; break; end
            tick(); cyc++;
        end
        chk("t2_if_granted", got, 1); chk("t2_if_gap", cyc, 3);
        tick(); if_req_valid = 0;
        smp(); chk("t2_mreq_if", mem_req_valid, 1); chk("t2_maddr_if", mem_addr, 64'h8000_0040);
        repeat (3) tick();

        // Continuous contention for four grants
        if_req_valid = 1; if_addr = 64'h8000_0100; ls_req_valid = 1; ls_addr = 64'h300;
        for (int g = 0; g < 4; g++) begin
            got = 0;
            for (int k = 0; k < 12; k++) begin
                smp();
                if (if_req_ready || ls_req_ready) begin got = 1; break; end
                tick();
            end
            if (!got) chk($sformatf("t3_timeout%0d", g), 0, 1);
            else chk($sformatf("t3_grant%0d_is_ls", g), ls_req_ready, exp3[g]);
            tick();
            if (g == 3) begin if_req_valid = 0; ls_req_valid = 0; end
        end
        repeat (4) tick();

        // Flush in IDLE blocks fetch but lets the LSU through
        if_req_valid = 1; if_flush = 1; if_addr = 64'h8000_0180;
        smp(); chk("tf_if_blocked", if_req_ready, 0);
        tick(); ls_req_valid = 1; ls_addr = 64'h380;
        smp(); chk("tf_ls_granted", ls_req_ready, 1); chk("tf_if_still_blocked", if_req_ready, 0);
        tick(); ls_req_valid = 0; if_req_valid = 0; if_flush = 0;
        repeat (4) tick();

        // LSU write with memory stalling three cycles
        ready_delay = 3;
        ls_req_valid = 1; ls_wen = 1; ls_addr = 64'h100; ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
        smp(); chk("t4_ls_ready", ls_req_ready, 1);
        tick(); ls_req_valid = 0; ls_wen = 0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
        for (int c = 0; c < 4; c++) begin
            smp();
            chk($sformatf("t4_mreq%0d", c), mem_req_valid, 1);
            chk($sformatf("t4_maddr%0d", c), mem_addr, 64'h100);
            chk($sformatf("t4_mwen%0d", c), mem_wen, 1);
            chk($sformatf("t4_mwdata%0d", c), mem_wdata, 64'hDEAD_BEEF);
            chk($sformatf("t4_mwmask%0d", c), mem_wmask, 8'h0F);
            tick();
        end
        ready_delay = 0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            smp(); if (ls_resp_valid) pulses++;
            tick();
        end
        chk("t4_ls_pulses", pulses, 1);

        // Fetch made stale while waiting; response arrives two cycles after the flush
        resp_delay = 3;
        if_req_valid = 1; if_addr = 64'h8000_0200;
        smp(); chk("t5_if_ready", if_req_ready, 1);
        tick(); if_req_valid = 0;
        smp(); chk("t5_mreq", mem_req_valid, 1);
        tick(); if_flush = 1;
        smp(); chk("t5_in_wait", mem_req_valid, 0);
        tick(); if_flush = 0; resp_delay = 1;
        smp(); chk("t5_noresp_c3", if_resp_valid, 0);
        tick();
        smp(); chk("t5_noresp_c4", if_resp_valid, 0);
        tick(); if_req_valid = 1; if_addr = 64'h8000_0300;
        smp(); chk("t5_noresp_c5", if_resp_valid, 0); chk("t5_new_accept", if_req_ready, 1);
        tick(); if_req_valid = 0;
        tick(); tick();
        smp(); chk("t5_resp_after", if_resp_valid, 1);
        chk("t5_data_after", if_rdata, 64'h8000_0300_7FFF_FCFF);
        repeat (2) tick();

        // Reset in REQ, then a late memory response
        ready_delay = 10;
        if_req_valid = 1; if_addr = 64'h8000_0400; ls_req_valid = 1; ls_addr = 64'h500;
        smp(); chk("t6_ls_ready", ls_req_ready, 1);
        tick(); ls_req_valid = 0;
        smp(); chk("t6_in_req", mem_req_valid, 1);
        tick(); reset = 0;
        smp(); chk("t6_rst_mreq", mem_req_valid, 0); chk("t6_rst_if_ready", if_req_ready, 0);
        chk("t6_rst_maddr", mem_addr, 0); chk("t6_rst_if_rdata", if_rdata, 0);
        tick(); reset = 1; if_req_valid = 0; ready_delay = 0;
        smp(); chk("t6_idle_after", mem_req_valid, 0);
        tick(); stray_resp = 1;
        tick(); stray_resp = 0;
        for (int c = 0; c < 3; c++) begin
            smp();
            chk($sformatf("t6_no_if_resp%0d", c), if_resp_valid, 0);
            chk($sformatf("t6_no_ls_resp%0d", c), ls_resp_valid, 0);
            tick();
        end

        repeat (2) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ysyx_22040931_mem_arbiter.md
# ysyx_22040931_mem_arbiter

Shares the core's single memory port between the fetch stage (instruction reads at `if_pc`) and the load/store unit. The arbiter runs a small FSM, holds one transaction in flight and routes each response back to its owner. It discards fetch responses that a branch redirect has made stale. It sits between the IF/LSU stages and the memory interface, and sets the fetch-issue cadence seen by the PC register.

## Interface
Parameters:
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: data width.
- `MASK_W`, default `DATA_W/8`: byte-strobe width.

Ports:
- `clock`  in  1  system clock; all state is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req_valid`  in  1  fetch request.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_addr`  in  ADDR_W  fetch address.
- `if_flush`  in  1  redirect; makes any fetch owned or being offered stale.
- `if_resp_valid`  out  1  one-cycle fetch response strobe.
- `if_rdata`  out  DATA_W  fetch data.
- `ls_req_valid`  in  1  LSU request.
- `ls_req_ready`  out  1  LSU request accepted.
- `ls_addr`  in  ADDR_W  LSU address.
- `ls_wen`  in  1  write when high.
- `ls_wdata`  in  DATA_W  LSU write data.
- `ls_wmask`  in  MASK_W  LSU byte strobes.
- `ls_resp_valid`  out  1  one-cycle LSU response strobe; asserted for writes too.
- `ls_rdata`  out  DATA_W  load data.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory request accepted.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wen`  out  1  memory write enable.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_wmask`  out  MASK_W  memory byte strobes.
- `mem_resp_valid`  in  1  memory response.
- `mem_rdata`  in  DATA_W  memory read data.

## Operation
- FSM states:
  - IDLE: arbitrate. On a grant, pulse the winner's `*_req_ready`, latch its addr/wen/wdata/wmask and the owner, then go to REQ.
  - REQ: drive `mem_req_valid` from the latched request. When `mem_req_ready` is high, go to WAIT.
  - WAIT: when `mem_resp_valid` is high, register the owner's `*_resp_valid` and rdata, then go to IDLE.
- Fetch requests are reads: `mem_wen`=0 and `mem_wmask`=0.
- Default priority: LSU wins whenever both request, because the LSU carries the older instruction.
- `if_flush` asserted in IDLE: `if_req_ready` is forced 0 that cycle, so an LSU request can still be granted.
- `if_flush` while the owner is IF in REQ or WAIT: set `drop`.
  - The memory transaction still completes, since a request cannot be retracted.
  - Its response is swallowed: `if_resp_valid` stays 0.
  - `drop` clears on return to IDLE.
- `mem_resp_valid` outside WAIT is ignored.
- `mem_req_valid`, `mem_addr`, `mem_wen`, `mem_wdata` and `mem_wmask` stay stable in REQ until the handshake completes.

## Timing
- Reset values:
  - State IDLE, owner IF, `drop`=0, RR pointer IF.
  - All `*_ready`, `*_resp_valid` and `mem_req_valid` outputs are 0.
  - Data outputs are 0.
- Best case, with `mem_req_ready`=1 immediately and a 1-cycle memory:
  - Accept at cycle N.
  - `mem_req_valid` at N+1.
  - WAIT at N+2, with `mem_resp_valid` at N+2.
  - `*_resp_valid` at N+3.
  - Next accept possible at N+3.
- Throughput: one transaction per 3 cycles at best; exactly one transaction is outstanding.
- Reset asserted mid-transaction returns everything to the reset values immediately. Any response the memory returns afterwards is ignored.

## Configuration
- `YSYX_22040931_ARB_RR_EN` defined:
  - Round-robin. When both sides request in IDLE, grant the side not granted most recently.
  - A one-bit `last_grant` register updates on every grant.
- `YSYX_22040931_ARB_RR_EN` undefined: fixed LSU priority and no `last_grant` register.

## Structure
- Add to `defines.v`:
  - State encodings `ysyx_22040931_ARB_IDLE`, `ysyx_22040931_ARB_REQ` and `ysyx_22040931_ARB_WAIT`.
  - Owner encodings `ysyx_22040931_ARB_OWN_IF` and `ysyx_22040931_ARB_OWN_LS`.
- One combinational sub-module, `ysyx_22040931_arb_pick`: inputs are the two valids, the flush and `last_grant`; outputs are the grant one-hot.
- The FSM, request latch and response registers stay in the top module.

## Test plan
- Fetch only, addr 0x8000_0000, memory ready at once and responding with 0x0000_0013 → `if_req_ready` at cycle 0, `mem_req_valid` at 1, `if_resp_valid` with `if_rdata`=0x13 at 3, `ls_resp_valid` never asserted.
- Both request in the same IDLE cycle, macro undefined → LSU granted first. IF is granted at the next IDLE, and `mem_addr` carries the IF address in that transaction's REQ.
- Both request continuously for 4 grants with the macro defined → grant order LS, IF, LS, IF.
- LSU write, addr 0x100, wdata 0xDEAD_BEEF, wmask 0x0F, `mem_req_ready` held low for 3 cycles → mem outputs hold steady for all 4 REQ cycles, and `ls_resp_valid` is pulsed once.
- IF transaction in WAIT, `if_flush` pulsed, memory responds 2 cycles later → no `if_resp_valid`; FSM returns to IDLE and accepts a new fetch next cycle.
- Reset driven low while in REQ → all outputs go to 0 within the same cycle, and a late `mem_resp_valid` produces no response strobe.
